led_line_arbiter: RTL and testbench

LED_LINE_ARBITER -- requirements
Module: led_line_arbiter

---
 rtl/led_line_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_led_line_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_line_arbiter.sv
// led_line_arbiter
//   Shares one LED-panel write port between two line-write requesters and a
//   full-panel clear. A granted line job walks the 32 columns of one panel
//   line, issuing one pixel write per column and waiting for ctrl_done
//   between writes. A clear job walks all 32x32 pixels writing zero.
//
// Ports
//   clk25        system clock, rising edge
//   resetn       synchronous, active-low reset
//   req[1:0]     per-requester line-write request, held until granted
//   line[9:0]    {line1,line0}   5-bit target panel line per requester
//   value[63:0]  {value1,value0} 32-bit on/off column mask per requester
//   color[47:0]  {color1,color0} 24-bit RGB colour per requester
//   grant[1:0]   one-cycle grant pulse; request fields captured that cycle
//   done[1:0]    one-cycle pulse when the granted job finishes or aborts
//   clear        one-cycle full-panel clear request
//   busy         high whenever the arbiter is not idle
//   timeout_err  sticky: a panel write never saw ctrl_done in time
//   ctrl_wr      panel write strobe (4'b0111 while a write is pending)
//   ctrl_addr    panel byte address
//   ctrl_wdat    pixel data {8'h00, rgb}
//   ctrl_done    panel write-complete pulse
module led_line_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk25,
    input  logic        resetn,
    input  logic [1:0]  req,
    input  logic [9:0]  line,
    input  logic [63:0] value,
    input  logic [47:0] color,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    input  logic        clear,
    output logic        busy,
    output logic        timeout_err,
    output logic [3:0]  ctrl_wr,
    output logic [15:0] ctrl_addr,
    output logic [31:0] ctrl_wdat,
    input  logic        ctrl_done
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
    localparam logic [2:0] S_NEXT     = 3'd3;
    localparam logic [2:0] S_COMPLETE = 3'd4;

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    // Per-requester views of the packed request buses.
    logic [4:0]  req_line  [2];
    logic [31:0] req_value [2];
    logic [23:0] req_color [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign req_line[gi]  = line[gi*5 +: 5];
            assign req_value[gi] = value[gi*32 +: 32];
            assign req_color[gi] = color[gi*24 +: 24];
        end
    endgenerate

    logic [2:0]     state_reg,       state_next;
    logic [4:0]     col_reg,         col_next;
    logic [4:0]     line_reg,        line_next;
    logic [31:0]    value_reg,       value_next;
    logic [23:0]    color_reg,       color_next;
    logic           owner_reg,       owner_next;
    logic           is_clear_reg,    is_clear_next;
    logic           rr_reg,          rr_next;       // 1: requester 1 favoured
    logic           clear_pend_reg,  clear_pend_next;
    logic [WCW-1:0] wait_cnt_reg,    wait_cnt_next;
    logic [1:0]     grant_reg,       grant_next;
    logic [1:0]     done_reg,        done_next;
    logic           timeout_err_reg, timeout_err_next;
    logic [3:0]     ctrl_wr_reg,     ctrl_wr_next;
    logic [15:0]    ctrl_addr_reg,   ctrl_addr_next;
    logic [31:0]    ctrl_wdat_reg,   ctrl_wdat_next;

    // Round-robin pick: requester 0 wins unless requester 1 is favoured
    // and also requesting (or requester 0 is not requesting at all).
    logic       pick;
    logic [4:0] row_offs;
    logic [1:0] owner_done;

    assign pick       = (req[0] && (!rr_reg || !req[1])) ? 1'b0 : 1'b1;
    // Panel columns are stored bottom line first, hence 31 - line.
    assign row_offs   = 5'd31 - line_reg;
    assign owner_done = is_clear_reg ? 2'b00 : (owner_reg ? 2'b10 : 2'b01);

    always_comb begin
        state_next       = state_reg;
        col_next         = col_reg;
        line_next        = line_reg;
        value_next       = value_reg;
        color_next       = color_reg;
        owner_next       = owner_reg;
        is_clear_next    = is_clear_reg;
        rr_next          = rr_reg;
        clear_pend_next  = clear_pend_reg | clear;
        wait_cnt_next    = wait_cnt_reg;
        grant_next       = 2'b00;
        done_next        = 2'b00;
        timeout_err_next = timeout_err_reg;
        ctrl_wr_next     = ctrl_wr_reg;
        ctrl_addr_next   = ctrl_addr_reg;
        ctrl_wdat_next   = ctrl_wdat_reg;

        case (state_reg)
            S_IDLE: begin
                if (clear_pend_reg) begin
                    // Only a clear arriving this very cycle survives the grant.
                    clear_pend_next = clear;
                    is_clear_next   = 1'b1;
                    line_next       = 5'd0;
                    col_next        = 5'd0;
                    value_next      = 32'h0;
                    color_next      = 24'h0;
                    state_next      = S_ISSUE;
                end else if (req != 2'b00) begin
                    grant_next[pick] = 1'b1;
                    owner_next       = pick;
                    rr_next          = ~pick;
                    is_clear_next    = 1'b0;
                    line_next        = req_line[pick];
                    value_next       = req_value[pick];
                    color_next       = req_color[pick];
                    col_next         = 5'd0;
                    state_next       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ctrl_addr_next = {4'b0000, col_reg, row_offs, 2'b00};
                ctrl_wdat_next = value_reg[col_reg] ? {8'h00, color_reg} : 32'h0;
                ctrl_wr_next   = 4'b0111;
                wait_cnt_next  = '0;
                state_next     = S_WAIT;
            end
            S_WAIT: begin
                if (ctrl_done) begin
                    ctrl_wr_next = 4'b0000;
                    state_next   = S_NEXT;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    // Panel stopped answering: abandon the rest of the job.
                    ctrl_wr_next     = 4'b0000;
                    timeout_err_next = 1'b1;
                    done_next        = owner_done;
                    state_next       = S_COMPLETE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WCW'(1);
                end
            end
            S_NEXT: begin
                col_next = col_reg + 5'd1;
                if (col_reg == 5'd31) begin
                    if (is_clear_reg && line_reg != 5'd31) begin
                        line_next  = line_reg + 5'd1;
                        state_next = S_ISSUE;
                    end else begin
                        done_next  = owner_done;
                        state_next = S_COMPLETE;
                    end
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_COMPLETE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk25) begin
        if (!resetn) begin
            state_reg       <= S_IDLE;
            col_reg         <= 5'd0;
            line_reg        <= 5'd0;
            value_reg       <= 32'h0;
            color_reg       <= 24'h0;
            owner_reg       <= 1'b0;
            is_clear_reg    <= 1'b0;
            rr_reg          <= 1'b0;
            clear_pend_reg  <= 1'b0;
            wait_cnt_reg    <= '0;
            grant_reg       <= 2'b00;
            done_reg        <= 2'b00;
            timeout_err_reg <= 1'b0;
            ctrl_wr_reg     <= 4'b0000;
            ctrl_addr_reg   <= 16'h0;
            ctrl_wdat_reg   <= 32'h0;
        end else begin
            state_reg       <= state_next;
            col_reg         <= col_next;
            line_reg        <= line_next;
            value_reg       <= value_next;
            color_reg       <= color_next;
            owner_reg       <= owner_next;
            is_clear_reg    <= is_clear_next;
            rr_reg          <= rr_next;
            clear_pend_reg  <= clear_pend_next;
            wait_cnt_reg    <= wait_cnt_next;
            grant_reg       <= grant_next;
            done_reg        <= done_next;
            timeout_err_reg <= timeout_err_next;
            ctrl_wr_reg     <= ctrl_wr_next;
            ctrl_addr_reg   <= ctrl_addr_next;
            ctrl_wdat_reg   <= ctrl_wdat_next;
        end
    end

    assign grant       = grant_reg;
    assign done        = done_reg;
    assign busy        = (state_reg != S_IDLE);
    assign timeout_err = timeout_err_reg;
    assign ctrl_wr     = ctrl_wr_reg;
    assign ctrl_addr   = ctrl_addr_reg;
    assign ctrl_wdat   = ctrl_wdat_reg;

endmodule

// File: tb/tb_led_line_arbiter.sv
`timescale 1ns/1ps
module tb_led_line_arbiter;
    localparam int TIMEOUT = 255;

    logic        clk25 = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [9:0]  line = '0;
    logic [63:0] value = '0;
    logic [47:0] color = '0;
    logic        clear = 1'b0;
    logic        ctrl_done = 1'b0;
    logic [1:0]  grant, done;
    logic        busy, timeout_err;
    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [31:0] ctrl_wdat;

    led_line_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk25(clk25), .resetn(resetn), .req(req), .line(line), .value(value),
        .color(color), .grant(grant), .done(done), .clear(clear), .busy(busy),
        .timeout_err(timeout_err), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr),
        .ctrl_wdat(ctrl_wdat), .ctrl_done(ctrl_done)
    );

    always #20 clk25 = ~clk25;

    int cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int fav = 0;                 // requester the round-robin should favour next

    typedef struct {logic [15:0] addr; logic [31:0] wdat; int cyc;} wr_t;
    typedef struct {logic [1:0] bits; int cyc;} ev_t;
    wr_t wr_q[$];
    wr_t exp_q[$];
    ev_t grant_q[$];
    ev_t done_q[$];
    int  wr_end_cyc = 0;
    int  unstable = 0;
    int  bad_strobe = 0;

    // Observer: logs write starts, grants and dones; watches write stability.
    initial begin
        logic [3:0]  prev_wr;
        logic [15:0] prev_addr;
        logic [31:0] prev_wdat;
        prev_wr = 4'b0000; prev_addr = '0; prev_wdat = '0;
        forever begin
            @(negedge clk25);
            if (resetn === 1'b1) begin
                if (ctrl_wr !== 4'b0000 && ctrl_wr !== 4'b0111) bad_strobe++;
                if (ctrl_wr != 0 && prev_wr == 0) wr_q.push_back('{ctrl_addr, ctrl_wdat, cyc});
                if (ctrl_wr != 0 && prev_wr != 0 &&
                    (ctrl_addr !== prev_addr || ctrl_wdat !== prev_wdat)) unstable++;
                if (ctrl_wr == 0 && prev_wr != 0) wr_end_cyc = cyc;
                if (grant != 0) grant_q.push_back('{grant, cyc});
                if (done != 0) done_q.push_back('{done, cyc});
            end
            prev_wr = ctrl_wr; prev_addr = ctrl_addr; prev_wdat = ctrl_wdat;
        end
    end

    // Panel model: answers each write with a ctrl_done after a random delay.
    bit resp_en = 1'b1;
    int resp_min = 2;
    int resp_max = 2;
    initial begin
        int cnt;
        int target;
        cnt = 0; target = 2;
        forever begin
            @(negedge clk25);
            if (resp_en) begin
                ctrl_done = 1'b0;
                if (ctrl_wr != 0) begin
                    if (cnt == 0) target = $urandom_range(resp_max, resp_min);
                    cnt++;
                    if (cnt == target) ctrl_done = 1'b1;
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end

    // Reference: one line job writes column c of line ln at pixel index
    // c*32 + (31-ln), four bytes per pixel; lit columns carry the colour.
    function automatic void model_line_job(input logic [4:0] ln, input logic [31:0] v,
                                           input logic [23:0] c);
        for (int col = 0; col < 32; col++) begin
            wr_t w;
            w.addr = 16'((col * 32 + 31 - int'(ln)) * 4);
            w.wdat = v[col] ? {8'h00, c} : 32'h0;
            w.cyc  = 0;
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_clear_job();
        for (int l = 0; l < 32; l++)
            for (int col = 0; col < 32; col++) begin
                wr_t w;
                w.addr = 16'((col * 32 + 31 - l) * 4);
                w.wdat = 32'h0;
                w.cyc  = 0;
                exp_q.push_back(w);
            end
    endfunction

    function automatic int count_wr_mismatch();
        int bad = 0;
        int n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].wdat !== exp_q[i].wdat) bad++;
        return bad;
    endfunction

    task automatic clear_logs();
        @(posedge clk25);
        #1;
        wr_q.delete(); exp_q.delete(); grant_q.delete(); done_q.delete();
        unstable = 0; bad_strobe = 0;
        @(negedge clk25);
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 2'b00; clear = 1'b0;
        repeat (3) @(posedge clk25);
        @(negedge clk25);
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant); end
        n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b expected 00", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        n_checks++; if (ctrl_wr !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl_wr: got %b expected 0000", ctrl_wr); end
        n_checks++; if (ctrl_addr !== 16'h0) begin n_fail++; $display("FAIL reset_ctrl_addr: got %h expected 0000", ctrl_addr); end
        n_checks++; if (ctrl_wdat !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl_wdat: got %h expected 0", ctrl_wdat); end
        resetn = 1'b1; fav = 0;
        @(negedge clk25);
        $display("reset: outputs checked after synchronous reset");
    endtask

    task automatic test_single_line();
        int t_req, k, bad;
        clear_logs();
        resp_min = 2; resp_max = 2;
        line = {5'd0, 5'd3}; value = {32'h0, 32'h0000_0001}; color = {24'h0, 24'h00ff00};
        req = 2'b01; t_req = cyc;
        k = 0; while (grant == 2'b00 && k < 10) begin @(negedge clk25); k++; end
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", grant); end
        n_checks++; if (cyc - t_req !== 1) begin n_fail++; $display("FAIL single_grant_latency: got %0d expected 1", cyc - t_req); end
        req = 2'b00; fav = 1;
        model_line_job(5'd3, 32'h0000_0001, 24'h00ff00);
        k = 0; while (done == 2'b00 && k < 2000) begin @(negedge clk25); k++; end
        n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b expected 01", done); end
        n_checks++; if (cyc - wr_end_cyc !== 1) begin n_fail++; $display("FAIL single_done_latency: got %0d expected 1", cyc - wr_end_cyc); end
        repeat (3) @(negedge clk25);
        bad = count_wr_mismatch();
        n_checks++; if (wr_q.size() !== 32) begin n_fail++; $display("FAIL single_write_count: got %0d expected 32", wr_q.size()); end
        n_checks++; if (wr_q[0].addr !== 16'h0070 || wr_q[0].wdat !== 32'h0000ff00) begin n_fail++;
            $display("FAIL single_col0: got %h/%h expected 0070/0000ff00", wr_q[0].addr, wr_q[0].wdat); end
        n_checks++; if (wr_q[1].addr !== 16'h00F0 || wr_q[1].wdat !== 32'h0) begin n_fail++;
            $display("FAIL single_col1: got %h/%h expected 00f0/00000000", wr_q[1].addr, wr_q[1].wdat); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL single_writes: got %0d bad writes expected 0", bad); end
        n_checks++; if (wr_q[0].cyc - t_req !== 2) begin n_fail++; $display("FAIL single_wr_latency: got %0d expected 2", wr_q[0].cyc - t_req); end
        n_checks++; if (done_q.size() !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", done_q.size()); end
        n_checks++; if (unstable !== 0 || bad_strobe !== 0) begin n_fail++;
            $display("FAIL single_wr_stable: got %0d/%0d violations expected 0/0", unstable, bad_strobe); end
        $display("single_line: %0d writes, %0d bad", wr_q.size(), bad);
    endtask

    task automatic test_random_lines();
        int r, k, bad;
        logic [4:0]  ln;
        logic [31:0] v;
        logic [23:0] c;
        clear_logs();
        resp_min = 1; resp_max = 3;
        for (int j = 0; j < 4; j++) begin
            r = $urandom_range(1, 0);
            ln = 5'($urandom); v = $urandom; c = 24'($urandom);
            line  = {5'($urandom), 5'($urandom)};
            value = {32'($urandom), 32'($urandom)};
            color = {24'($urandom), 24'($urandom)};
            line[r*5 +: 5] = ln; value[r*32 +: 32] = v; color[r*24 +: 24] = c;
            req = 2'b01 << r;
            k = 0; while (grant == 2'b00 && k < 10) begin @(negedge clk25); k++; end
            n_checks++; if (grant !== (2'b01 << r)) begin n_fail++; $display("FAIL rand_grant: got %b expected %b", grant, 2'b01 << r); end
            req = 2'b00; fav = 1 - r;
            model_line_job(ln, v, c);
            // Fields are captured at grant: scramble them now.
            line = 10'($urandom); value = {$urandom, $urandom}; color = 48'({$urandom, $urandom});
            k = 0; while (done == 2'b00 && k < 2000) begin @(negedge clk25); k++; end
            n_checks++; if (done !== (2'b01 << r)) begin n_fail++; $display("FAIL rand_done: got %b expected %b", done, 2'b01 << r); end
            $display("rand_job %0d: requester %0d line %0d value %h color %h", j, r, ln, v, c);
            @(negedge clk25);
        end
        repeat (2) @(negedge clk25);
        bad = count_wr_mismatch();
        n_checks++; if (wr_q.size() !== 128) begin n_fail++; $display("FAIL rand_write_count: got %0d expected 128", wr_q.size()); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand_writes: got %0d bad writes expected 0", bad); end
    endtask

    task automatic test_withdrawn();
        int k;
        clear_logs();
        resp_min = 1; resp_max = 2;
        line = {5'd9, 5'd17}; value = {32'hFFFF_0000, 32'h0F0F_0F0F}; color = {24'h123456, 24'hABCDEF};
        req = 2'b01;
        k = 0; while (grant == 2'b00 && k < 10) begin @(negedge clk25); k++; end
        req = 2'b00; fav = 1;
        model_line_job(5'd17, 32'h0F0F_0F0F, 24'hABCDEF);
        repeat (6) @(negedge clk25);
        req = 2'b10;                    // requester 1 asks, then withdraws
        repeat (4) @(negedge clk25);
        req = 2'b00;
        k = 0; while (done == 2'b00 && k < 2000) begin @(negedge clk25); k++; end
        repeat (6) @(negedge clk25);
        n_checks++; if (grant_q.size() !== 1) begin n_fail++; $display("FAIL withdrawn_grants: got %0d grants expected 1", grant_q.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL withdrawn_idle: got busy %b expected 0", busy); end
        n_checks++; if (count_wr_mismatch() !== 0 || wr_q.size() !== 32) begin n_fail++;
            $display("FAIL withdrawn_writes: got %0d writes %0d bad expected 32/0", wr_q.size(), count_wr_mismatch()); end
        $display("withdrawn: %0d grants observed", grant_q.size());
    endtask

    task automatic test_round_robin();
        int k, nd, ng, bad;
        logic [4:0]  ln [2];
        logic [31:0] v  [2];
        logic [23:0] c  [2];
        clear_logs();
        resp_min = 1; resp_max = 2;
        for (int i = 0; i < 2; i++) begin ln[i] = 5'($urandom); v[i] = $urandom; c[i] = 24'($urandom); end
        line = {ln[1], ln[0]}; value = {v[1], v[0]}; color = {c[1], c[0]};
        req = 2'b11; nd = 0; ng = 0; k = 0;
        while (nd < 4 && k < 4000) begin
            @(negedge clk25); k++;
            if (grant != 2'b00) begin
                n_checks++; if (grant !== (2'b01 << fav)) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", ng, grant, 2'b01 << fav); end
                $display("rr: grant %b at cycle %0d", grant, cyc);
                model_line_job(ln[fav], v[fav], c[fav]);
                fav = 1 - fav; ng++;
            end
            if (done != 2'b00) begin nd++; if (nd == 4) req = 2'b00; end
        end
        repeat (4) @(negedge clk25);
        n_checks++; if (grant_q.size() !== 4 || done_q.size() !== 4) begin n_fail++;
            $display("FAIL rr_counts: got %0d grants %0d dones expected 4/4", grant_q.size(), done_q.size()); end
        bad = 0;
        for (int i = 0; i < 4 && i < grant_q.size() && i < done_q.size(); i++) begin
            if (done_q[i].bits !== grant_q[i].bits) bad++;
            if (i > 0 && done_q[i-1].cyc >= grant_q[i].cyc) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rr_order: got %0d ordering errors expected 0", bad); end
        n_checks++; if (count_wr_mismatch() !== 0 || wr_q.size() !== 128) begin n_fail++;
            $display("FAIL rr_writes: got %0d writes %0d bad expected 128/0", wr_q.size(), count_wr_mismatch()); end
    endtask

    task automatic test_clear();
        int k;
        logic [4:0]  ln0, ln1;
        logic [31:0] v0, v1;
        logic [23:0] c0, c1;
        clear_logs();
        resp_min = 1; resp_max = 1;
        ln0 = 5'($urandom); v0 = $urandom; c0 = 24'($urandom);
        ln1 = 5'($urandom); v1 = $urandom; c1 = 24'($urandom);
        line = {ln1, 5'd0}; value = {v1, 32'h0}; color = {c1, 24'h0};
        req = 2'b10;
        k = 0; while (grant == 2'b00 && k < 10) begin @(negedge clk25); k++; end
        n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL clear_first_grant: got %b expected 10", grant); end
        fav = 0;
        model_line_job(ln1, v1, c1);
        line = {5'd0, ln0}; value = {32'h0, v0}; color = {24'h0, c0};
        req = 2'b01;
        repeat (5) @(negedge clk25);
        clear = 1'b1;
        @(negedge clk25);
        clear = 1'b0;
        model_clear_job();
        model_line_job(ln0, v0, c0);
        k = 0; while (grant == 2'b00 && k < 10000) begin @(negedge clk25); k++; end
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL clear_second_grant: got %b expected 01", grant); end
        req = 2'b00; fav = 1;
        k = 0; while (done == 2'b00 && k < 2000) begin @(negedge clk25); k++; end
        repeat (3) @(negedge clk25);
        n_checks++; if (grant_q.size() !== 2) begin n_fail++; $display("FAIL clear_grant_count: got %0d expected 2", grant_q.size()); end
        n_checks++; if (done_q.size() !== 2 || done_q[0].bits !== 2'b10 || done_q[1].bits !== 2'b01) begin n_fail++;
            $display("FAIL clear_dones: got %0d dones first %b expected 2 dones 10 then 01", done_q.size(), done_q[0].bits); end
        n_checks++; if (wr_q.size() !== 1088) begin n_fail++; $display("FAIL clear_write_count: got %0d expected 1088", wr_q.size()); end
        n_checks++; if (count_wr_mismatch() !== 0) begin n_fail++; $display("FAIL clear_writes: got %0d bad writes expected 0", count_wr_mismatch()); end
        $display("clear: %0d writes total, grants %0d", wr_q.size(), grant_q.size());
    endtask

    task automatic test_timeout();
        int k;
        clear_logs();
        resp_en = 1'b0; ctrl_done = 1'b0;
        line = {5'd2, 5'd7}; value = {32'h1, 32'h1}; color = {24'h111111, 24'h222222};
        req = 2'b01;
        k = 0; while (grant == 2'b00 && k < 10) begin @(negedge clk25); k++; end
        req = 2'b00; fav = 1;
        k = 0; while (ctrl_wr == 4'b0000 && k < 10) begin @(negedge clk25); k++; end
        k = 0; while (ctrl_wr != 4'b0000 && k < 1000) begin @(negedge clk25); k++; end
        n_checks++; if (k !== TIMEOUT) begin n_fail++; $display("FAIL timeout_wr_cycles: got %0d expected %0d", k, TIMEOUT); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b expected 1", timeout_err); end
        k = 0; while (done == 2'b00 && k < 5) begin @(negedge clk25); k++; end
        n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL timeout_done: got %b expected 01", done); end
        @(negedge clk25);
        n_checks++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL timeout_writes: got %0d expected 1", wr_q.size()); end
        resp_en = 1'b1; resp_min = 1; resp_max = 2;
        req = 2'b10;
        k = 0; while (grant == 2'b00 && k < 10) begin @(negedge clk25); k++; end
        n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL timeout_new_grant: got %b expected 10", grant); end
        req = 2'b00; fav = 0;
        k = 0; while (done == 2'b00 && k < 2000) begin @(negedge clk25); k++; end
        n_checks++; if (done !== 2'b10) begin n_fail++; $display("FAIL timeout_new_done: got %b expected 10", done); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b expected 1", timeout_err); end
        $display("timeout: strobe held %0d cycles, recovered", TIMEOUT);
    endtask

    task automatic test_reset_midjob();
        int k, nw;
        logic [3:0] pw;
        clear_logs();
        resp_min = 2; resp_max = 2;
        line = {5'd0, 5'd12}; value = {32'h0, 32'hDEAD_BEEF}; color = {24'h0, 24'h0000FF};
        req = 2'b01;
        k = 0; while (grant == 2'b00 && k < 10) begin @(negedge clk25); k++; end
        req = 2'b00;
        nw = 0; pw = 4'b0000; k = 0;
        while (nw < 10 && k < 1000) begin
            @(negedge clk25); k++;
            if (ctrl_wr != 0 && pw == 0) nw++;
            pw = ctrl_wr;
        end
        resetn = 1'b0;
        resp_en = 1'b0; ctrl_done = 1'b0;
        @(negedge clk25);
        n_checks++; if (ctrl_wr !== 4'b0000) begin n_fail++; $display("FAIL midreset_ctrl_wr: got %b expected 0000", ctrl_wr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL midreset_timeout_err: got %b expected 0", timeout_err); end
        resetn = 1'b1; fav = 0;
        @(negedge clk25);
        ctrl_done = 1'b1;
        @(negedge clk25);
        ctrl_done = 1'b0;
        repeat (5) @(negedge clk25);
        n_checks++; if (busy !== 1'b0 || ctrl_wr !== 4'b0000) begin n_fail++;
            $display("FAIL midreset_stray_done: got busy %b wr %b expected 0/0000", busy, ctrl_wr); end
        n_checks++; if (done_q.size() !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d dones expected 0", done_q.size()); end
        n_checks++; if (wr_q.size() !== 10) begin n_fail++; $display("FAIL midreset_writes: got %0d expected 10", wr_q.size()); end
        resp_en = 1'b1;
        req = 2'b11;
        k = 0; while (grant == 2'b00 && k < 10) begin @(negedge clk25); k++; end
        n_checks++; if (grant !== (2'b01 << fav)) begin n_fail++; $display("FAIL midreset_rr_start: got %b expected %b", grant, 2'b01 << fav); end
        req = 2'b00; fav = 1;
        k = 0; while (done == 2'b00 && k < 2000) begin @(negedge clk25); k++; end
        n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL midreset_after_done: got %b expected 01", done); end
        $display("reset_midjob: reset during write %0d, job discarded", nw);
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_random_lines();
        test_withdrawn();
        test_round_robin();
        test_clear();
        test_timeout();
        test_reset_midjob();
        repeat (3) @(negedge clk25);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
